// File: rtl/riscv_mem_responder_pkg.sv
// Shared definitions for the TCM responder: response classes, address and
// tag widths, and the request-throttling LFSR constants and step function.
package riscv_mem_responder_pkg;

  localparam logic [31:0] MEM_BASE_DEFAULT = 32'h8000_0000;
  localparam int          TAG_W            = 11;

  // Throttle LFSR: 16-bit Fibonacci, taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Classification of an accepted data-port request
  typedef enum logic [1:0] {
    RESP_READ,
    RESP_WRITE,
    RESP_CTRL,
    RESP_ERR
  } respType_e;

  // Data-port response payload carried through the latency pipe
  typedef struct packed {
    logic [31:0]      data;
    logic             error;
    logic [TAG_W-1:0] tag;
  } dResp_t;

  // Fetch-port response payload carried through the latency pipe
  typedef struct packed {
    logic [31:0] inst;
    logic        error;
  } iResp_t;

  function automatic logic [15:0] lfsrNext(input logic [15:0] state);
    return {state[14:0], ^(state & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/riscv_mem_responder_if.sv
// Bus bundle between the core (master) and the TCM responder (slave):
// instruction-fetch port and data port request/response signals.
interface riscv_mem_responder_if
  import riscv_mem_responder_pkg::*;
();

  // Fetch port
  logic             mem_i_rd_i;
  logic             mem_i_flush_i;
  logic             mem_i_invalidate_i;
  logic [31:0]      mem_i_pc_i;
  logic             mem_i_accept_o;
  logic             mem_i_valid_o;
  logic             mem_i_error_o;
  logic [31:0]      mem_i_inst_o;

  // Data port
  logic [31:0]      mem_d_addr_i;
  logic [31:0]      mem_d_data_wr_i;
  logic             mem_d_rd_i;
  logic [3:0]       mem_d_wr_i;
  logic             mem_d_cacheable_i;
  logic [TAG_W-1:0] mem_d_req_tag_i;
  logic             mem_d_invalidate_i;
  logic             mem_d_flush_i;
  logic [31:0]      mem_d_data_rd_o;
  logic             mem_d_accept_o;
  logic             mem_d_ack_o;
  logic             mem_d_error_o;
  logic [TAG_W-1:0] mem_d_resp_tag_o;

  modport master (
    output mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i,
    input  mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
    output mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i,
    output mem_d_cacheable_i, mem_d_req_tag_i, mem_d_invalidate_i, mem_d_flush_i,
    input  mem_d_data_rd_o, mem_d_accept_o, mem_d_ack_o, mem_d_error_o,
    input  mem_d_resp_tag_o
  );

  modport slave (
    input  mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i,
    output mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
    input  mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i,
    input  mem_d_cacheable_i, mem_d_req_tag_i, mem_d_invalidate_i, mem_d_flush_i,
    output mem_d_data_rd_o, mem_d_accept_o, mem_d_ack_o, mem_d_error_o,
    output mem_d_resp_tag_o
  );

endinterface

// File: rtl/riscv_mem_resp_pipe.sv
// Fixed-latency response pipe: a valid bit plus payload shifted one stage per
// clock, RESP_LATENCY stages deep. Idle stages carry an all-zero payload so
// the outputs read zero whenever valid_o is low. Synchronous active-low clear.
module riscv_mem_resp_pipe #(
  parameter int WIDTH        = 1,
  parameter int RESP_LATENCY = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] payload_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] payload_o
);

  logic [RESP_LATENCY-1:0] valid_q;
  logic [WIDTH-1:0]        payload_q [RESP_LATENCY];

  // Shift responses towards the output; reset drops everything in flight
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      for (int s = 0; s < RESP_LATENCY; s++) begin
        payload_q[s] <= '0;
      end
    end else begin
      valid_q[0]   <= valid_i;
      payload_q[0] <= valid_i ? payload_i : '0;
      for (int s = 1; s < RESP_LATENCY; s++) begin
        valid_q[s]   <= valid_q[s-1];
        payload_q[s] <= payload_q[s-1];
      end
    end
  end

  assign valid_o   = valid_q[RESP_LATENCY-1];
  assign payload_o = payload_q[RESP_LATENCY-1];

endmodule

// File: rtl/riscv_mem_responder.sv
// Tightly-coupled memory responder for the core's fetch and data ports.
// Reads sample the word array at the accepting edge, byte writes land on the
// same edge, and responses come back in order RESP_LATENCY cycles later.
// Build option RISCV_MEM_RESP_STALL_EN: a free-running LFSR randomly drops
// accept on each port (about a quarter of cycles) to exercise core stalls.
module riscv_mem_responder
  import riscv_mem_responder_pkg::*;
#(
  parameter logic [31:0] MEM_BASE     = MEM_BASE_DEFAULT,
  parameter int          MEM_AW       = 14,
  parameter int          RESP_LATENCY = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  riscv_mem_responder_if.slave        bus
);

  localparam logic [31:0] MEM_BYTES = 32'd4 << MEM_AW;

  logic [31:0]       memArray_q [2**MEM_AW];
  logic              ready_q;
  logic              dStall;
  logic              iStall;

  logic              dWrAny;
  logic              dReq;
  logic              dFire;
  logic [31:0]       dOffset;
  logic              dInRange;
  logic [MEM_AW-1:0] dIndex;
  respType_e         dType;
  logic              dWrEn;
  dResp_t            dRespIn;
  dResp_t            dRespOut;
  logic              dValid;

  logic              iReq;
  logic              iFire;
  logic [31:0]       iOffset;
  logic              iInRange;
  logic [MEM_AW-1:0] iIndex;
  iResp_t            iRespIn;
  iResp_t            iRespOut;
  logic              iValid;

  logic              unusedSink;

  // Accepts are held low through reset and come up on the first cycle after
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

`ifdef RISCV_MEM_RESP_STALL_EN
  logic [15:0] lfsr_q;

  // Free-running throttle sequence, restarted from the seed on every reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsrNext(lfsr_q);
    end
  end

  assign dStall = &lfsr_q[1:0];
  assign iStall = &lfsr_q[3:2];
`else
  assign dStall = 1'b0;
  assign iStall = 1'b0;
`endif

  assign bus.mem_d_accept_o = ready_q & ~dStall;
  assign bus.mem_i_accept_o = ready_q & ~iStall;

  // Decode the data-port request into a response class and its payload
  always_comb begin
    dWrAny   = |bus.mem_d_wr_i;
    dReq     = bus.mem_d_rd_i | dWrAny | bus.mem_d_flush_i | bus.mem_d_invalidate_i;
    dFire    = dReq & bus.mem_d_accept_o & rst_i;
    dOffset  = bus.mem_d_addr_i - MEM_BASE;
    dInRange = (bus.mem_d_addr_i >= MEM_BASE) && (dOffset < MEM_BYTES);
    dIndex   = dOffset[MEM_AW+1:2];
    dType    = RESP_CTRL;
    if (bus.mem_d_rd_i && dWrAny) begin
      dType = RESP_ERR;
    end else if (bus.mem_d_rd_i) begin
      dType = dInRange ? RESP_READ : RESP_ERR;
    end else if (dWrAny) begin
      dType = dInRange ? RESP_WRITE : RESP_ERR;
    end
    dWrEn         = dFire && (dType == RESP_WRITE);
    dRespIn.data  = (dType == RESP_READ) ? memArray_q[dIndex] : 32'h0;
    dRespIn.error = (dType == RESP_ERR);
    dRespIn.tag   = bus.mem_d_req_tag_i;
  end

  // Decode the fetch-port request; flush and invalidate are accepted silently
  always_comb begin
    iReq           = bus.mem_i_rd_i | bus.mem_i_flush_i | bus.mem_i_invalidate_i;
    iFire          = iReq & bus.mem_i_accept_o & rst_i;
    iOffset        = bus.mem_i_pc_i - MEM_BASE;
    iInRange       = (bus.mem_i_pc_i >= MEM_BASE) && (iOffset < MEM_BYTES);
    iIndex         = iOffset[MEM_AW+1:2];
    iRespIn.inst   = iInRange ? memArray_q[iIndex] : 32'h0;
    iRespIn.error  = ~iInRange;
  end

  // Byte-strobed write into the array; contents survive reset
  always_ff @(posedge clk_i) begin
    if (dWrEn) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_d_wr_i[b]) begin
          memArray_q[dIndex][8*b +: 8] <= bus.mem_d_data_wr_i[8*b +: 8];
        end
      end
    end
  end

  riscv_mem_resp_pipe #(
    .WIDTH        ($bits(dResp_t)),
    .RESP_LATENCY (RESP_LATENCY)
  ) u_dPipe (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (dFire),
    .payload_i (dRespIn),
    .valid_o   (dValid),
    .payload_o (dRespOut)
  );

  riscv_mem_resp_pipe #(
    .WIDTH        ($bits(iResp_t)),
    .RESP_LATENCY (RESP_LATENCY)
  ) u_iPipe (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (iFire & bus.mem_i_rd_i),
    .payload_i (iRespIn),
    .valid_o   (iValid),
    .payload_o (iRespOut)
  );

  assign bus.mem_d_ack_o      = dValid;
  assign bus.mem_d_data_rd_o  = dValid ? dRespOut.data : 32'h0;
  assign bus.mem_d_error_o    = dValid & dRespOut.error;
  assign bus.mem_d_resp_tag_o = dValid ? dRespOut.tag : '0;

  assign bus.mem_i_valid_o    = iValid;
  assign bus.mem_i_inst_o     = iValid ? iRespOut.inst : 32'h0;
  assign bus.mem_i_error_o    = iValid & iRespOut.error;

  assign unusedSink = bus.mem_d_cacheable_i;

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Self-checking bench for riscv_mem_responder: a reference word model and
// accept/throttle model predict every response, which is queued when a
// request is accepted and compared when the responder acks.
module tb_riscv_mem_responder;
  import riscv_mem_responder_pkg::*;

  localparam int          LAT  = 3;
  localparam int          AW   = 14;
  localparam logic [31:0] BASE = 32'h8000_0000;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [10:0] tag;
    int          due;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t        dq[$];
  exp_t        iq[$];
  logic [31:0] model [int];
  logic        readyM = 1'b0;
  logic [15:0] lfsrM  = 16'hACE1;

  always #5 clk_i = ~clk_i;

  riscv_mem_responder_if bus();

  riscv_mem_responder #(
    .MEM_BASE     (BASE),
    .MEM_AW       (AW),
    .RESP_LATENCY (LAT)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic inRange(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'h0001_0000);
  endfunction

  function automatic int wordKey(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic dPending();
    return bus.mem_d_rd_i | (|bus.mem_d_wr_i) | bus.mem_d_flush_i | bus.mem_d_invalidate_i;
  endfunction

  function automatic logic iPending();
    return bus.mem_i_rd_i | bus.mem_i_flush_i | bus.mem_i_invalidate_i;
  endfunction

  task automatic setD(input logic [31:0] addr, input logic [31:0] data, input logic rd,
                      input logic [3:0] wr, input logic [10:0] tag,
                      input logic fl = 1'b0, input logic inv = 1'b0);
    bus.mem_d_addr_i       = addr;
    bus.mem_d_data_wr_i    = data;
    bus.mem_d_rd_i         = rd;
    bus.mem_d_wr_i         = wr;
    bus.mem_d_req_tag_i    = tag;
    bus.mem_d_flush_i      = fl;
    bus.mem_d_invalidate_i = inv;
  endtask

  task automatic setI(input logic [31:0] pc, input logic rd,
                      input logic fl = 1'b0, input logic inv = 1'b0);
    bus.mem_i_pc_i         = pc;
    bus.mem_i_rd_i         = rd;
    bus.mem_i_flush_i      = fl;
    bus.mem_i_invalidate_i = inv;
  endtask

  task automatic clearD();
    setD(32'h0, 32'h0, 1'b0, 4'h0, 11'h0);
  endtask

  task automatic clearI();
    setI(32'h0, 1'b0);
  endtask

  // Compare any responses visible this cycle against the queued expectations
  task automatic monitor();
    exp_t e;
    if (bus.mem_d_ack_o) begin
      if (dq.size() == 0) begin
        checkOutput("d_spurious_ack", bus.mem_d_ack_o, 0);
      end else begin
        e = dq.pop_front();
        checkOutput("d_data", bus.mem_d_data_rd_o, e.data);
        checkOutput("d_error", bus.mem_d_error_o, e.err);
        checkOutput("d_tag", bus.mem_d_resp_tag_o, e.tag);
        checkOutput("d_latency", cyc, e.due);
      end
    end else begin
      checkOutput("d_idle_tag", bus.mem_d_resp_tag_o, 0);
      if (dq.size() > 0 && dq[0].due <= cyc) begin
        checkOutput("d_ack_missing", bus.mem_d_ack_o, 1);
        e = dq.pop_front();
      end
    end
    if (bus.mem_i_valid_o) begin
      if (iq.size() == 0) begin
        checkOutput("i_spurious_valid", bus.mem_i_valid_o, 0);
      end else begin
        e = iq.pop_front();
        checkOutput("i_inst", bus.mem_i_inst_o, e.data);
        checkOutput("i_error", bus.mem_i_error_o, e.err);
        checkOutput("i_latency", cyc, e.due);
      end
    end else if (iq.size() > 0 && iq[0].due <= cyc) begin
      checkOutput("i_valid_missing", bus.mem_i_valid_o, 1);
      e = iq.pop_front();
    end
  endtask

  // One clock: check accepts, score responses, record expectations for the
  // requests accepted at the coming edge, then step past that edge
  task automatic applyStimulus(output bit dAcc, output bit iAcc);
    exp_t        e;
    logic [31:0] w;
    logic        rstAtEdge;
    logic        expDAcc;
    logic        expIAcc;
    @(negedge clk_i);
    expDAcc = readyM;
    expIAcc = readyM;
`ifdef RISCV_MEM_RESP_STALL_EN
    expDAcc = readyM & ~(lfsrM[1] & lfsrM[0]);
    expIAcc = readyM & ~(lfsrM[3] & lfsrM[2]);
`endif
    checkOutput("d_accept", bus.mem_d_accept_o, expDAcc);
    checkOutput("i_accept", bus.mem_i_accept_o, expIAcc);
    monitor();
    rstAtEdge = rst_i;
    dAcc = 1'b0;
    iAcc = 1'b0;
    if (!rstAtEdge) begin
      dq.delete();
      iq.delete();
    end else begin
      dAcc = dPending() && expDAcc;
      iAcc = iPending() && expIAcc;
      if (iAcc && bus.mem_i_rd_i) begin
        e.due = cyc + LAT;
        e.tag = 11'h0;
        e.err = !inRange(bus.mem_i_pc_i);
        e.data = e.err ? 32'h0 : model[wordKey(bus.mem_i_pc_i)];
        iq.push_back(e);
      end
      if (dAcc) begin
        e.due  = cyc + LAT;
        e.tag  = bus.mem_d_req_tag_i;
        e.data = 32'h0;
        e.err  = 1'b0;
        if (bus.mem_d_rd_i && (|bus.mem_d_wr_i)) begin
          e.err = 1'b1;
        end else if (bus.mem_d_rd_i) begin
          if (inRange(bus.mem_d_addr_i)) e.data = model[wordKey(bus.mem_d_addr_i)];
          else e.err = 1'b1;
        end else if (|bus.mem_d_wr_i) begin
          if (inRange(bus.mem_d_addr_i)) begin
            w = model.exists(wordKey(bus.mem_d_addr_i)) ? model[wordKey(bus.mem_d_addr_i)] : 32'h0;
            for (int b = 0; b < 4; b++) begin
              if (bus.mem_d_wr_i[b]) w[8*b +: 8] = bus.mem_d_data_wr_i[8*b +: 8];
            end
            model[wordKey(bus.mem_d_addr_i)] = w;
          end else begin
            e.err = 1'b1;
          end
        end
        dq.push_back(e);
      end
    end
    @(posedge clk_i);
    cyc++;
    if (!rstAtEdge) begin
      readyM = 1'b0;
      lfsrM  = 16'hACE1;
    end else begin
      readyM = 1'b1;
      lfsrM  = {lfsrM[14:0], lfsrM[15] ^ lfsrM[13] ^ lfsrM[12] ^ lfsrM[10]};
    end
    #1;
  endtask

  // Hold the driven requests until each port has accepted its own
  task automatic issue();
    bit dA;
    bit iA;
    int n = 0;
    while ((dPending() || iPending()) && n < 64) begin
      applyStimulus(dA, iA);
      if (dA) clearD();
      if (iA) clearI();
      n++;
    end
    checkOutput("issue_accepted", {dPending(), iPending()}, 2'b00);
    clearD();
    clearI();
  endtask

  task automatic drain();
    bit dA;
    bit iA;
    repeat (LAT + 2) applyStimulus(dA, iA);
    checkOutput("d_drain", dq.size(), 0);
    checkOutput("i_drain", iq.size(), 0);
  endtask

  initial begin
    bit          dA;
    bit          iA;
    int          op;
    logic [31:0] addr;

    clearD();
    clearI();
    bus.mem_d_cacheable_i = 1'b0;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Reset: outputs quiet while held, accepts rise once released
    repeat (3) applyStimulus(dA, iA);
    checkOutput("rst_d_accept", bus.mem_d_accept_o, 0);
    checkOutput("rst_i_accept", bus.mem_i_accept_o, 0);
    checkOutput("rst_d_ack", bus.mem_d_ack_o, 0);
    checkOutput("rst_d_data", bus.mem_d_data_rd_o, 0);
    checkOutput("rst_d_error", bus.mem_d_error_o, 0);
    checkOutput("rst_i_valid", bus.mem_i_valid_o, 0);
    checkOutput("rst_i_inst", bus.mem_i_inst_o, 0);
    checkOutput("rst_i_error", bus.mem_i_error_o, 0);
    rst_i = 1'b1;
    applyStimulus(dA, iA);

    // Preload the low 64 words with a known pattern
    for (int k = 0; k < 64; k++) begin
      setD(BASE + 32'(k * 4), 32'h1122_3344 ^ 32'(k * 32'h0101_0101), 1'b0, 4'hF, 11'(k));
      issue();
    end
    drain();

    // Partial byte write then read back with distinct tags
    setD(32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 4'b0011, 11'h155);
    issue();
    setD(32'h8000_0010, 32'h0, 1'b1, 4'h0, 11'h2AA);
    issue();
    drain();
    checkOutput("model_partial", model[4], {16'h1526, 16'hBEEF});

    // Back-to-back fetch stream
    for (int k = 0; k < 8; k++) begin
      setI(BASE + 32'(k * 4), 1'b1);
      issue();
    end
    drain();

    // Out-of-range accesses, rd+wr conflict, control requests
    setD(32'h7FFF_FFFC, 32'h0, 1'b1, 4'h0, 11'h011);
    issue();
    setD(32'h8001_0000, 32'h0, 1'b1, 4'h0, 11'h012);
    issue();
    setD(32'h8001_0000, 32'hFFFF_FFFF, 1'b0, 4'hF, 11'h013);
    issue();
    setD(32'h8000_0000, 32'h0, 1'b1, 4'h0, 11'h014);
    issue();
    setD(32'h8000_0008, 32'h5555_5555, 1'b1, 4'hF, 11'h015);
    issue();
    setD(32'h8000_0008, 32'h0, 1'b1, 4'h0, 11'h016);
    issue();
    setD(32'h8000_0000, 32'h0, 1'b0, 4'h0, 11'h017, 1'b1, 1'b0);
    issue();
    setD(32'h8000_0000, 32'h0, 1'b0, 4'h0, 11'h018, 1'b0, 1'b1);
    issue();
    setI(32'h8001_0000, 1'b1);
    issue();
    setI(32'h8000_0004, 1'b0, 1'b1, 1'b1);
    issue();
    drain();

    // Same-edge write and fetch of one word, then refetch
    setD(32'h8000_0040, 32'hCAFE_F00D, 1'b0, 4'hF, 11'h040);
    setI(32'h8000_0040, 1'b1);
    issue();
    setI(32'h8000_0040, 1'b1);
    issue();
    drain();

    // Reset with reads in flight drops them; array contents survive
    setD(32'h8000_0020, 32'h0, 1'b1, 4'h0, 11'h021);
    issue();
    setD(32'h8000_0024, 32'h0, 1'b1, 4'h0, 11'h022);
    issue();
    rst_i = 1'b0;
    repeat (3) applyStimulus(dA, iA);
    rst_i = 1'b1;
    applyStimulus(dA, iA);
    drain();
    setD(32'h8000_0024, 32'h0, 1'b1, 4'h0, 11'h023);
    issue();
    drain();

    // Random traffic on both ports
    for (int n = 0; n < 1000; n++) begin
      op   = int'($urandom_range(0, 9));
      addr = BASE + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
      case (op)
        0, 1, 2: setD(addr, 32'h0, 1'b1, 4'h0, 11'($urandom_range(0, 2047)));
        3, 4:    setD(addr, $urandom, 1'b0, 4'($urandom_range(1, 15)), 11'($urandom_range(0, 2047)));
        5:       setD(addr, $urandom, 1'b1, 4'($urandom_range(1, 15)), 11'($urandom_range(0, 2047)));
        6:       setD(addr, 32'h0, 1'b0, 4'h0, 11'($urandom_range(0, 2047)), 1'b1, 1'b0);
        7:       setD(32'h8001_0000 + ($urandom_range(0, 255) << 2), 32'h0, 1'b1, 4'h0,
                      11'($urandom_range(0, 2047)));
        default: clearD();
      endcase
      op = int'($urandom_range(0, 9));
      if (op < 7) setI(BASE + ($urandom_range(0, 63) << 2), 1'b1);
      else if (op == 7) setI(32'h7FFF_FFF0, 1'b1);
      else if (op == 8) setI(BASE, 1'b0, 1'b1, 1'b0);
      else clearI();
      applyStimulus(dA, iA);
    end
    clearD();
    clearI();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
